mux4: RTL and testbench

- Four-input, WIDTH-bit multiplexer with a 2-bit select.
- Primary output y is purely combinational; the bench samples it 1 ns after any input change.
- Also provides a registered copy of the selected word and select, with enable, for pipelined datapath use.
- Sits in the shared datapath library; instantiated wherever a 4:1 word select is needed.

---
 rtl/mux4.sv | 58 +++++
 tb/tb_mux4.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4.sv
// mux4: four-input, WIDTH-bit word multiplexer with a 2-bit select.
//
// y is the purely combinational selected word. y_q/s_q are a registered copy
// of the selected word and of the select that produced it, loaded on a rising
// clk while en is high, for use in pipelined datapaths.
//
// Ports:
//   clk    - system clock, rising-edge active
//   reset  - asynchronous, active-high; clears y_q/s_q only
//   d0..d3 - WIDTH-bit data inputs, selected by s = 00/01/10/11
//   s      - 2-bit select
//   en     - load enable for y_q/s_q
//   y      - combinational selected word
//   y_q    - registered selected word
//   s_q    - registered select that produced y_q
module mux4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       s_q
);

    localparam int unsigned SEL_W = 2;

    // Word select; an unknown select propagates as all-X in simulation and is
    // a don't-care for synthesis.
    always_comb begin
        y = 'x;
        case (s)
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            2'b11:   y = d3;
            default: y = 'x;
        endcase
    end

    // Registered copy of the selected word and its select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q <= '0;
            s_q <= SEL_W'(0);
        end else if (en) begin
            y_q <= y;
            s_q <= s;
        end
    end

endmodule

// File: tb/tb_mux4.sv
// tb_mux4: directed, scoreboard-driven bench for mux4 at WIDTH = 4 and 8.
module tb_mux4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d0, d1, d2, d3;
    logic [1:0] s;
    logic       en;
    logic [3:0] y, y_q;
    logic [1:0] s_q;

    logic [7:0] w0, w1, w2, w3;
    logic [1:0] s8;
    logic       en8;
    logic [7:0] y8, y8_q;
    logic [1:0] s8_q;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mux4 #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .s     (s),
        .en    (en),
        .y     (y),
        .y_q   (y_q),
        .s_q   (s_q)
    );

    mux4 #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .d0    (w0),
        .d1    (w1),
        .d2    (w2),
        .d3    (w3),
        .s     (s8),
        .en    (en8),
        .y     (y8),
        .y_q   (y8_q),
        .s_q   (s8_q)
    );

    task automatic push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h, no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Global time bound so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: timeout observed, required completion before 50000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat [4];
        pat[0] = 8'h00; pat[1] = 8'h55; pat[2] = 8'hAA; pat[3] = 8'hFF;

        reset = 1'b0; en = 1'b0; en8 = 1'b0;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0; s = 2'b00;
        w0 = 8'h00; w1 = 8'h00; w2 = 8'h00; w3 = 8'h00; s8 = 2'b00;

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        push("reset_yq", 8'h00);  check(8'(y_q));
        push("reset_sq", 8'h00);  check(8'(s_q));
        push("reset_y8q", 8'h00); check(y8_q);
        push("reset_s8q", 8'h00); check(8'(s8_q));
        d2 = 4'b1011; s = 2'b10;
        push("reset_y_follows", 8'h0B);
        #1;
        check(8'(y));

        // Combinational sweep while reset is high (y ignores reset and en).
        for (int i = 0; i < 4; i++) begin
            d0 = 4'(i); d1 = 4'(4 + i); d2 = 4'(8 + i); d3 = 4'(12 + i);
            for (int sv = 0; sv < 4; sv++) begin
                s = 2'(sv);
                push("sweep_y", 8'(4 * sv + i));
                #1;
                check(8'(y));
            end
        end

        // Registers hold 0 through a clock edge while reset is high.
        en = 1'b1;
        @(posedge clk);
        #1;
        push("reset_hold_yq", 8'h00); check(8'(y_q));
        push("reset_hold_sq", 8'h00); check(8'(s_q));

        // Release reset with en low; still 0 after the next edge.
        @(negedge clk);
        en = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push("release_yq", 8'h00); check(8'(y_q));

        // Registered load.
        @(negedge clk);
        en = 1'b1; d1 = 4'b0101; s = 2'b01;
        #1;
        push("load_y_pre", 8'h05); check(8'(y));
        @(posedge clk);
        #1;
        push("load_yq", 8'h05); check(8'(y_q));
        push("load_sq", 8'h01); check(8'(s_q));

        // Hold with en low.
        @(negedge clk);
        en = 1'b0; s = 2'b11; d3 = 4'b1111;
        #1;
        push("hold_y", 8'h0F); check(8'(y));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            push("hold_yq", 8'h05); check(8'(y_q));
            push("hold_sq", 8'h01); check(8'(s_q));
        end

        // Mid-operation reset with en high every cycle.
        @(negedge clk);
        en = 1'b1; s = 2'b10; d2 = 4'h6;
        @(posedge clk);
        #1;
        push("run_yq_a", 8'h06); check(8'(y_q));
        push("run_sq_a", 8'h02); check(8'(s_q));
        @(negedge clk);
        s = 2'b00; d0 = 4'h9;
        @(posedge clk);
        #1;
        push("run_yq_b", 8'h09); check(8'(y_q));
        push("run_sq_b", 8'h00); check(8'(s_q));
        @(negedge clk);
        s = 2'b11; d3 = 4'hC;
        #1;
        reset = 1'b1;
        #1;
        push("midrst_yq", 8'h00); check(8'(y_q));
        push("midrst_sq", 8'h00); check(8'(s_q));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            push("midrst_hold_yq", 8'h00); check(8'(y_q));
            push("midrst_hold_sq", 8'h00); check(8'(s_q));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        push("midrst_rel_yq", 8'h00); check(8'(y_q));
        @(posedge clk);
        #1;
        push("midrst_load_yq", 8'h0C); check(8'(y_q));
        push("midrst_load_sq", 8'h03); check(8'(s_q));

        // WIDTH = 8 sweep with registered follow-up.
        @(negedge clk);
        en = 1'b0;
        w0 = pat[0]; w1 = pat[1]; w2 = pat[2]; w3 = pat[3];
        en8 = 1'b1;
        for (int sv = 0; sv < 4; sv++) begin
            @(negedge clk);
            s8 = 2'(sv);
            #1;
            push("w8_y", pat[sv]); check(y8);
            @(posedge clk);
            #1;
            push("w8_yq", pat[sv]);  check(y8_q);
            push("w8_sq", 8'(sv));   check(8'(s8_q));
        end

        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
